hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/bubble controller for the 5-stage pipeline.
- Drives the stall input of the F and D pipeline registers, plus a bubble (NOP-insert) to the E register.
- Detects load-use hazards and sequences the multi-cycle multiply/divide unit (HI/LO busy tracking).
- Sits beside the pipeline registers; consumes decoded register-use info from D and destination/op info from E.

Parameters:
- MULT_LAT, 5, cycles HI/LO are busy after a mult/multu issues from E (1..15).
- DIV_LAT, 10, cycles HI/LO are busy after a div/divu issues from E (1..15).
- CNT_W, 4, busy-counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- D_rs  input  5  rs field of the instruction in D.
- D_rt  input  5  rt field of the instruction in D.
- D_use_rs  input  1  D instruction reads rs.
- D_use_rt  input  1  D instruction reads rt.
- D_use_hilo  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_dst  input  5  destination register of the instruction in E (0 = none).
- E_mem_read  input  1  E instruction is a load.
- E_md_start  input  1  E instruction is mult/multu/div/divu (issues this cycle).
- E_md_div  input  1  with E_md_start: 1 = divide latency, 0 = multiply latency.
- F_stall  output  1  hold the PC/F register.
- D_stall  output  1  hold the D register.
- E_bubble  output  1  load a NOP into E this cycle.
- md_busy  output  1  HI/LO unit busy (counter nonzero).
- md_err  output  1  sticky flag: E_md_start seen while busy.

Behaviour:
- Reset (rst_n low, asynchronous): busy counter = 0, md_err = 0. Outputs then follow the combinational rules below with md_busy = 0; with idle inputs, F_stall = D_stall = E_bubble = 0.
- Load-use hazard, combinational: lu = E_mem_read & (E_dst != 0) & ((D_use_rs & D_rs == E_dst) | (D_use_rt & D_rt == E_dst)).
- HI/LO hazard, combinational: md = D_use_hilo & (md_busy | E_md_start).
- Stall merge: stall = lu | md. F_stall = D_stall = E_bubble = stall, all in the same cycle with zero latency.
- Busy counter (registered), evaluated on each clk edge in priority order:
  - E_md_start & counter == 0: load DIV_LAT if E_md_div, else MULT_LAT.
  - Otherwise, counter != 0: decrement by 1, saturating at 0.
  - Otherwise: hold.
- md_busy = (counter != 0), registered-derived.
  - Busy spans exactly LAT cycles following the issue edge.
  - A D hilo instruction stalls exactly LAT+1 cycles when it is directly behind the md op.
- E_md_start while counter != 0 is illegal, since D should have been stalled. Required behaviour:
  - Ignore the start; the counter continues decrementing.
  - Set md_err at the next edge; it stays 1 until reset.
- Simultaneous lu and md: a single stall; no extra cycles are added.
- Reset mid-operation: the counter clears immediately; the stall deasserts in the same cycle unless lu is true.
- E_dst == 0 never causes a load-use stall, even with a matching rs/rt of 0.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- Defined:
  - Adds outputs lu_stall_cnt[31:0] and md_stall_cnt[31:0].
  - Each increments by 1 on every clk edge where lu (respectively md) is 1.
  - md_stall_cnt counts only when lu = 0, so the two counts are mutually exclusive.
  - Both wrap from 0xFFFFFFFF to 0 and reset asynchronously to 0.
- Not defined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: REG_ZERO = 5'd0, default MULT_LAT/DIV_LAT constants, opcode/funct constants used to generate D_use_* and E_md_* in the decoder.
- Sub-module md_busy_cnt:
  - Contains the loadable down-counter, md_busy and md_err logic.
  - Parameterised by MULT_LAT, DIV_LAT, CNT_W.
- Hazard compare logic stays flat in hazard_ctrl.

Test Plan:
- Reset, then a load-use hazard:
  - Reset asserted mid-stream -> counter 0, md_err 0; with idle inputs F_stall = D_stall = E_bubble = 0.
  - Release reset, drive E_mem_read=1, E_dst=8, D_use_rs=1, D_rs=8 -> stall=1 that cycle.
  - Change D_rs to 9 -> stall=0.
  - With E_dst=0, D_rs=0 -> stall=0.
- mult issue with E_md_start=1, E_md_div=0, D_use_hilo=1 (mflo in D) -> stall=1 at the issue cycle. Then md_busy=1 for 5 cycles and stall=1 for 6 cycles total; cycle 7 stall=0.
- div issue with E_md_div=1, D_use_hilo=0 -> md_busy=1 for 10 cycles, no stall. At busy cycle 4, set D_use_hilo=1 -> stall=1 for the remaining 7 cycles.
- Illegal restart: E_md_start=1 at busy cycle 2 of a mult -> counter unaffected (busy ends on schedule); md_err=1 from the next edge until rst_n low.
- Reset mid-div: rst_n low at busy cycle 3 with D_use_hilo=1 -> md_busy=0 and stall=0 immediately, without waiting for clk.
- With HAZARD_CTRL_PERF_EN: 3 load-use stalls, then a 5-cycle mult stall overlapped by 1 load-use cycle -> lu_stall_cnt=4, md_stall_cnt=4.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the 5-stage pipeline control blocks.
//   - REG_ZERO           : architectural zero register index
//   - MULT_LAT_DEF       : default HI/LO busy cycles after mult/multu
//   - DIV_LAT_DEF        : default HI/LO busy cycles after div/divu
//   - OP_* / FN_*        : opcode and SPECIAL funct encodings that the
//                          decoder uses to build D_use_* and E_md_*
//   - is_*_funct helpers : small classification helpers for the decoder
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [4:0] REG_ZERO     = 5'd0;

    localparam int         MULT_LAT_DEF = 5;
    localparam int         DIV_LAT_DEF  = 10;
    localparam int         CNT_W_DEF    = 4;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL   = 6'h00;
    localparam logic [5:0] OP_LB        = 6'h20;
    localparam logic [5:0] OP_LH        = 6'h21;
    localparam logic [5:0] OP_LW        = 6'h23;
    localparam logic [5:0] OP_LBU       = 6'h24;
    localparam logic [5:0] OP_LHU       = 6'h25;

    // SPECIAL funct codes touching HI/LO
    localparam logic [5:0] FN_MFHI      = 6'h10;
    localparam logic [5:0] FN_MTHI      = 6'h11;
    localparam logic [5:0] FN_MFLO      = 6'h12;
    localparam logic [5:0] FN_MTLO      = 6'h13;
    localparam logic [5:0] FN_MULT      = 6'h18;
    localparam logic [5:0] FN_MULTU     = 6'h19;
    localparam logic [5:0] FN_DIV       = 6'h1A;
    localparam logic [5:0] FN_DIVU      = 6'h1B;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_kind_e;

    // Any SPECIAL instruction that reads or writes HI/LO
    function automatic logic is_hilo_funct(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) &&
               ((fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) ||
                (fn == FN_MTLO) || (fn == FN_MULT) || (fn == FN_MULTU) ||
                (fn == FN_DIV)  || (fn == FN_DIVU));
    endfunction

    // Classifies the instructions that start the multi-cycle unit
    function automatic md_kind_e md_kind(input logic [5:0] op, input logic [5:0] fn);
        if (op != OP_SPECIAL)
            return MD_NONE;
        if ((fn == FN_MULT) || (fn == FN_MULTU))
            return MD_MULT;
        if ((fn == FN_DIV) || (fn == FN_DIVU))
            return MD_DIV;
        return MD_NONE;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// ---------------------------------------------------------------------------
// md_busy_cnt
// HI/LO busy tracker for the multi-cycle multiply/divide unit.
// A loadable down-counter is armed with MULT_LAT or DIV_LAT when an md
// operation issues from E while idle; busy is simply "counter nonzero".
// A start seen while already busy is ignored and latches a sticky error.
//
// Ports:
//   clk        in   pipeline clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i_md_start in   E holds mult/multu/div/divu this cycle
//   i_md_div   in   1 = divide latency, 0 = multiply latency
//   o_busy     out  HI/LO unit busy
//   o_err      out  sticky: start requested while busy
// ---------------------------------------------------------------------------
module md_busy_cnt #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_md_start,
    input  logic i_md_div,
    output logic o_busy,
    output logic o_err
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_idle;

    assign w_idle = (r_cnt == CNT_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_ZERO;
            r_err <= 1'b0;
        end else begin
            if (i_md_start && w_idle)
                r_cnt <= i_md_div ? DIV_LOAD : MULT_LOAD;
            else if (!w_idle)
                r_cnt <= r_cnt - CNT_ONE;

            // An overlapping start means D was not held back; flag it and keep
            // the running operation's schedule intact.
            if (i_md_start && !w_idle)
                r_err <= 1'b1;
        end
    end

    assign o_busy = !w_idle;
    assign o_err  = r_err;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Stall/bubble controller for the 5-stage pipeline. Holds F and D and
// injects a NOP into E on a load-use hazard or when a HI/LO consumer in D
// meets a busy (or just-issuing) multiply/divide unit.
//
// Optional build macro: HAZARD_CTRL_PERF_EN
//   When defined, adds 32-bit wrapping stall counters lu_stall_cnt and
//   md_stall_cnt (md counted only in cycles without a load-use stall).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   D_rs, D_rt          source register fields of the D instruction
//   D_use_rs, D_use_rt  D instruction reads rs / rt
//   D_use_hilo          D instruction touches HI/LO
//   E_dst               destination register of E (0 = none)
//   E_mem_read          E instruction is a load
//   E_md_start          E issues mult/multu/div/divu this cycle
//   E_md_div            divide (1) or multiply (0) latency
//   F_stall, D_stall    hold F / D registers
//   E_bubble            load NOP into E
//   md_busy             HI/LO unit busy
//   md_err              sticky illegal-restart flag
// ---------------------------------------------------------------------------
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_use_rs,
    input  logic       D_use_rt,
    input  logic       D_use_hilo,
    input  logic [4:0] E_dst,
    input  logic       E_mem_read,
    input  logic       E_md_start,
    input  logic       E_md_div,
    output logic       F_stall,
    output logic       D_stall,
    output logic       E_bubble,
    output logic       md_busy,
    output logic       md_err
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    logic w_md_busy;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_lu;
    logic w_md;
    logic w_stall;

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_md_start (E_md_start),
        .i_md_div   (E_md_div),
        .o_busy     (w_md_busy),
        .o_err      (md_err)
    );

    // r0 is never a real producer, so a load "to r0" can't create a hazard.
    assign w_rs_hit = D_use_rs && (D_rs == E_dst);
    assign w_rt_hit = D_use_rt && (D_rt == E_dst);
    assign w_lu     = E_mem_read && (E_dst != REG_ZERO) && (w_rs_hit || w_rt_hit);

    // Including E_md_start covers the issue cycle, before the counter loads.
    assign w_md     = D_use_hilo && (w_md_busy || E_md_start);

    assign w_stall  = w_lu || w_md;

    assign F_stall  = w_stall;
    assign D_stall  = w_stall;
    assign E_bubble = w_stall;
    assign md_busy  = w_md_busy;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] r_lu_stall_cnt;
    logic [31:0] r_md_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_stall_cnt <= 32'd0;
            r_md_stall_cnt <= 32'd0;
        end else begin
            if (w_lu)
                r_lu_stall_cnt <= r_lu_stall_cnt + 32'd1;
            // Overlapped cycles are attributed to load-use only.
            if (w_md && !w_lu)
                r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
        end
    end

    assign lu_stall_cnt = r_lu_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] D_rs, D_rt, E_dst;
    logic       D_use_rs, D_use_rt, D_use_hilo;
    logic       E_mem_read, E_md_start, E_md_div;
    logic       F_stall, D_stall, E_bubble, md_busy, md_err;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] lu_stall_cnt, md_stall_cnt;
`endif

    int total  = 0;
    int passed = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_use_rs   (D_use_rs),
        .D_use_rt   (D_use_rt),
        .D_use_hilo (D_use_hilo),
        .E_dst      (E_dst),
        .E_mem_read (E_mem_read),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .E_bubble   (E_bubble),
        .md_busy    (md_busy),
        .md_err     (md_err)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".F_stall"},  {31'd0, F_stall},  {31'd0, exp});
        chk({tag, ".D_stall"},  {31'd0, D_stall},  {31'd0, exp});
        chk({tag, ".E_bubble"}, {31'd0, E_bubble}, {31'd0, exp});
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_rs = 5'd0; D_rt = 5'd0; E_dst = 5'd0;
        D_use_rs = 1'b0; D_use_rt = 1'b0; D_use_hilo = 1'b0;
        E_mem_read = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // ---- reset asserted mid-stream (mult in flight) ----
        E_md_start = 1'b1;
        #1 chk("pre_issue_busy", {31'd0, md_busy}, 32'd0);
        tick();
        E_md_start = 1'b0;
        #1 chk("inflight_busy", {31'd0, md_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_err",  {31'd0, md_err},  32'd0);
        chk_stall("rst_idle", 1'b0);
        tick();
        rst_n = 1'b1;

        // ---- load-use hazard ----
        E_mem_read = 1'b1; E_dst = 5'd8; D_use_rs = 1'b1; D_rs = 5'd8;
        #1 chk_stall("lu_rs_hit", 1'b1);
        D_rs = 5'd9;
        #1 chk_stall("lu_rs_miss", 1'b0);
        D_use_rt = 1'b1; D_rt = 5'd8;
        #1 chk_stall("lu_rt_hit", 1'b1);
        D_use_rt = 1'b0;
        E_dst = 5'd0; D_rs = 5'd0;
        #1 chk_stall("lu_r0", 1'b0);
        E_mem_read = 1'b0; E_dst = 5'd8; D_rs = 5'd8;
        #1 chk_stall("lu_not_load", 1'b0);
        idle();
        tick();

        // ---- mult issue with mflo directly behind ----
        E_md_start = 1'b1; E_md_div = 1'b0; D_use_hilo = 1'b1;
        #1 chk_stall("mult_issue", 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            E_md_start = 1'b0;
            #1;
            chk($sformatf("mult_busy%0d", i), {31'd0, md_busy}, 32'd1);
            chk_stall($sformatf("mult_stall%0d", i), 1'b1);
        end
        tick();
        #1;
        chk("mult_done_busy", {31'd0, md_busy}, 32'd0);
        chk_stall("mult_done", 1'b0);
        idle();
        tick();

        // ---- div issue, hilo consumer arrives at busy cycle 4 ----
        E_md_start = 1'b1; E_md_div = 1'b1;
        #1 chk_stall("div_issue", 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            E_md_start = 1'b0;
            if (i == 4) D_use_hilo = 1'b1;
            #1;
            chk($sformatf("div_busy%0d", i), {31'd0, md_busy}, 32'd1);
            chk_stall($sformatf("div_stall%0d", i), (i >= 4));
        end
        tick();
        #1;
        chk("div_done_busy", {31'd0, md_busy}, 32'd0);
        chk_stall("div_done", 1'b0);
        idle();
        tick();

        // ---- illegal restart at busy cycle 2 of a mult ----
        E_md_start = 1'b1; E_md_div = 1'b0;
        tick();
        E_md_start = 1'b0;
        #1 chk("ill_err_c1", {31'd0, md_err}, 32'd0);
        tick();
        E_md_start = 1'b1; E_md_div = 1'b1;
        #1 chk("ill_err_c2", {31'd0, md_err}, 32'd0);
        tick();
        E_md_start = 1'b0; E_md_div = 1'b0;
        #1;
        chk("ill_err_c3", {31'd0, md_err}, 32'd1);
        chk("ill_busy_c3", {31'd0, md_busy}, 32'd1);
        tick();
        tick();
        #1 chk("ill_busy_c5", {31'd0, md_busy}, 32'd1);
        tick();
        #1;
        chk("ill_busy_c6", {31'd0, md_busy}, 32'd0);
        chk("ill_err_hold", {31'd0, md_err}, 32'd1);

        // ---- reset mid-div with hilo consumer waiting ----
        E_md_start = 1'b1; E_md_div = 1'b1;
        tick();
        E_md_start = 1'b0; E_md_div = 1'b0;
        tick();
        tick();
        D_use_hilo = 1'b1;
        #1;
        chk("rdiv_busy_c3", {31'd0, md_busy}, 32'd1);
        chk_stall("rdiv_stall_c3", 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rdiv_busy_rst", {31'd0, md_busy}, 32'd0);
        chk("rdiv_err_rst",  {31'd0, md_err},  32'd0);
        chk_stall("rdiv_stall_rst", 1'b0);
        E_mem_read = 1'b1; E_dst = 5'd3; D_use_rs = 1'b1; D_rs = 5'd3;
        #1 chk_stall("rdiv_lu_in_rst", 1'b1);
        idle();
        tick();
        rst_n = 1'b1;

`ifdef HAZARD_CTRL_PERF_EN
        // ---- performance counters ----
        #1;
        chk("perf_lu0", lu_stall_cnt, 32'd0);
        chk("perf_md0", md_stall_cnt, 32'd0);
        E_mem_read = 1'b1; E_dst = 5'd4; D_use_rt = 1'b1; D_rt = 5'd4;
        repeat (3) tick();
        idle();
        #1;
        chk("perf_lu3", lu_stall_cnt, 32'd3);
        chk("perf_md_after_lu", md_stall_cnt, 32'd0);
        E_md_start = 1'b1; E_md_div = 1'b0;
        tick();
        E_md_start = 1'b0;
        D_use_hilo = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) begin
                E_mem_read = 1'b1; E_dst = 5'd6; D_use_rs = 1'b1; D_rs = 5'd6;
            end else begin
                E_mem_read = 1'b0; E_dst = 5'd0; D_use_rs = 1'b0; D_rs = 5'd0;
            end
            #1 chk_stall($sformatf("perf_stall%0d", i), 1'b1);
            tick();
        end
        idle();
        #1;
        chk("perf_lu_final", lu_stall_cnt, 32'd4);
        chk("perf_md_final", md_stall_cnt, 32'd4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
